fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the FIFO write port (2..16).
REQ-002 Parameter: dwidth, 5, data word width, equal to the FIFO dwidth.
REQ-003 Parameter: BURST_LEN, 4, maximum consecutive transfers per lock; used only when burst is compiled in (2..255).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  asynchronous active-high reset.
REQ-007 Port: req  in  NREQ  per-requester write request; requester i holds req[i] and its data stable until a transfer.
REQ-008 Port: data_in  in  NREQ*dwidth  flattened requester data; requester i occupies bits [i*dwidth +: dwidth].
REQ-009 Port: fifo_full  in  1  full flag from the downstream FIFO.
REQ-010 Port: gnt  out  NREQ  one-hot or zero grant; a transfer for requester i occurs on a rising edge where req[i] and gnt[i] are both high.
REQ-011 Port: fifo_wr_en  out  1  FIFO write enable, equal to OR of gnt.
REQ-012 Port: fifo_data  out  dwidth  data of the granted requester, or zero when gnt is zero.
REQ-013 Port: owner  out  clog2(NREQ)  index of the last granted requester (registered).

Function
REQ-014 gnt, fifo_wr_en and fifo_data are combinational from req, fifo_full and registered state: zero-cycle grant latency, and the FIFO captures data on the same edge.
REQ-015 gnt is zero whenever fifo_full=1; no write is ever issued to a full FIFO.
REQ-016 gnt is at most one-hot, and gnt[i]=1 only when req[i]=1.
REQ-017 Round-robin: priority search starts at index owner+1 mod NREQ and wraps; the first requesting index wins.
REQ-018 owner updates to the winner index on every transfer edge and is otherwise held.
REQ-019 States are ARB (free arbitration) and LOCK (burst in progress); LOCK is reachable only when burst is compiled in.
REQ-020 A requester that drops req without having been granted is skipped; its request is not remembered.
REQ-021 fifo_full deasserting produces a grant in the same cycle with no bubble.
REQ-022 Starvation bound: with all NREQ requesting continuously and the FIFO not full, each requester is granted at least once in every NREQ transfers (or NREQ*BURST_LEN transfers with burst).

Reset
REQ-023 While rst=1: state is ARB, owner is NREQ-1 (requester 0 has top priority first), the burst counter is 0, gnt is 0, fifo_wr_en is 0 and fifo_data is 0, regardless of req.
REQ-024 Reset asserted mid-burst aborts the lock immediately; no partial-state carryover.

Configuration
REQ-025 Macro FIFO_ARB_BURST_EN, when defined: after a transfer in ARB, enter LOCK on the winner; in LOCK only owner may be granted, and the counter increments per transfer.
REQ-026 With FIFO_ARB_BURST_EN, LOCK returns to ARB when owner drops req, or after its BURST_LEN-th transfer. A full stall holds LOCK without counting.
REQ-027 With FIFO_ARB_BURST_EN, the counter is clog2(BURST_LEN+1) bits and resets to 0 on each LOCK entry.
REQ-028 Without FIFO_ARB_BURST_EN: the state stays ARB, the counter is absent, BURST_LEN is ignored, and the grant rotates after every transfer.

Structure
REQ-029 Package fifo_arb_pkg holds the state encoding (ARB=0, LOCK=1) and the default NREQ, dwidth and BURST_LEN constants.
REQ-030 Sub-module rr_pick (combinational): inputs req and start index; outputs a one-hot winner and a valid flag. It is instantiated once.
REQ-031 The target is 120-400 RTL lines, and the block is verified against the fifo module with dwidth=5 and awidth=8 (depth 256).

Verification
REQ-032 The bench shall assert rst with req=4'b1111 -> gnt=0, fifo_wr_en=0 and owner=3 until release; the first grant after release goes to requester 0.
REQ-033 The bench shall apply req=4'b1111 with the FIFO never full, burst off -> gnt sequence 0001,0010,0100,1000,0001, and the FIFO reads back data in that order.
REQ-034 The bench shall apply req=4'b0101 with data 5'd3 on requester 0 and 5'd9 on requester 2 -> alternating writes 3,9,3,9, and requesters 1 and 3 are never granted.
REQ-035 The bench shall fill the FIFO to 256 entries with req held -> gnt=0 while full; one FIFO read -> exactly one grant in the next cycle, and no overflow or lost word.
REQ-036 The bench shall run with FIFO_ARB_BURST_EN, BURST_LEN=4 and req=4'b0011 -> four consecutive grants to 0, then four to 1. Requester 0 dropping req after 2 grants -> hand-off to 1 on the next edge.
REQ-037 The bench shall assert rst during LOCK after 2 of 4 burst transfers -> gnt=0 immediately; after release, arbitration restarts at requester 0 with the counter at 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and state encoding for the FIFO write-port arbiter.
// FIFO_ARB_BURST_EN (see fifo_wr_arb.sv) enables the burst-lock feature.
package fifo_arb_pkg;

   localparam int unsigned NReqDefault     = 4;
   localparam int unsigned DWidthDefault   = 5;
   localparam int unsigned BurstLenDefault = 4;

   typedef enum logic {
      StArb  = 1'b0,
      StLock = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after start_i, wrapping.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] start_i,
   output logic [N-1:0]         gnt_o,
   output logic                 valid_o
);

   localparam int unsigned W = $clog2(N);
   localparam logic [W:0] NVal = (W + 1)'(N);

   always_comb begin
      logic [W:0] pos;
      logic       found;
      gnt_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         // start_i < N and k < N, so one conditional subtract wraps into range
         pos = {1'b0, start_i} + k[W:0];
         if (pos >= NVal) begin
            pos = pos - NVal;
         end
         if (!found && req_i[pos[W-1:0]]) begin
            gnt_o[pos[W-1:0]] = 1'b1;
            found             = 1'b1;
         end
      end
   end

   assign valid_o = |gnt_o;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, zero-latency grant.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for up to BURST_LEN transfers.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = NReqDefault,
   parameter int unsigned dwidth    = DWidthDefault,
   parameter int unsigned BURST_LEN = BurstLenDefault
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*dwidth-1:0]   data_in,
   input  logic                     fifo_full,
   output logic [NREQ-1:0]          gnt,
   output logic                     fifo_wr_en,
   output logic [dwidth-1:0]        fifo_data,
   output logic [$clog2(NREQ)-1:0]  owner
);

   localparam int unsigned OW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("fifo_wr_arb: NREQ must be within 2..16");
   end
   if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_bad_burst
      $error("fifo_wr_arb: BURST_LEN must be within 2..255");
   end

   logic [OW-1:0]   owner_q;
   logic [OW-1:0]   start_idx;
   logic [OW-1:0]   win_idx;
   logic [NREQ-1:0] owner_oh;
   logic [NREQ-1:0] req_eff;
   logic [NREQ-1:0] pick_oh;
   logic            pick_vld;
   logic            xfer;
   logic            lock_hold;

   assign owner_oh  = NREQ'(1) << owner_q;
   assign start_idx = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   // A lock only restricts the search while its owner keeps requesting; once the owner
   // drops, another requester can win in that same cycle.
   assign req_eff   = lock_hold ? (req & owner_oh) : req;

   rr_pick #(
      .N(NREQ)
   ) u_pick (
      .req_i  (req_eff),
      .start_i(start_idx),
      .gnt_o  (pick_oh),
      .valid_o(pick_vld)
   );

   always_comb begin
      gnt       = '0;
      fifo_data = '0;
      win_idx   = '0;
      if (!rst && !fifo_full && pick_vld) begin
         gnt = pick_oh;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            fifo_data = data_in[i*dwidth +: dwidth];
            win_idx   = i[OW-1:0];
         end
      end
   end

   assign fifo_wr_en = |gnt;
   assign xfer       = fifo_wr_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OW'(NREQ - 1);
      end else if (xfer) begin
         owner_q <= win_idx;
      end
   end

   assign owner = owner_q;

`ifdef FIFO_ARB_BURST_EN
   localparam int unsigned CW = $clog2(BURST_LEN + 1);
   // The entry transfer is the first of the burst, so the lock counts BURST_LEN-1 more.
   localparam logic [CW-1:0] LastCnt = CW'(BURST_LEN - 2);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StArb;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (xfer) begin
         if (lock_hold) begin
            if (cnt_q == LastCnt) begin
               state_d = StArb;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            state_d = StLock;
            cnt_d   = '0;
         end
      end else if (state_q == StLock && !req[owner_q]) begin
         state_d = StArb;
         cnt_d   = '0;
      end
   end

   assign lock_hold = (state_q == StLock) && req[owner_q];
`else
   assign lock_hold = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb; the bench models the 256-deep downstream FIFO.
// Build with FIFO_ARB_BURST_EN defined to exercise the burst-lock checks.
module tb_fifo_wr_arb;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DW    = 5;
   localparam int unsigned BL    = 4;
   localparam int unsigned DEPTH = 256;
`ifdef FIFO_ARB_BURST_EN
   localparam bit BurstOn = 1'b1;
`else
   localparam bit BurstOn = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ*DW-1:0]   data_in;
   logic                 fifo_full;
   logic [NREQ-1:0]      gnt;
   logic                 fifo_wr_en;
   logic [DW-1:0]        fifo_data;
   logic [1:0]           owner;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]   fifo_q[$];
   logic [DW-1:0]   exp_q[$];
   logic [NREQ-1:0] last_gnt;

   // Reference model: last winner, whether a burst lock is live, transfers in that burst.
   int m_owner;
   bit m_locked;
   int m_burst_n;

   fifo_wr_arb #(
      .NREQ     (NREQ),
      .dwidth   (DW),
      .BURST_LEN(BL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .fifo_full (fifo_full),
      .gnt       (gnt),
      .fifo_wr_en(fifo_wr_en),
      .fifo_data (fifo_data),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_winner(input logic [NREQ-1:0] r, input logic full);
      if (full) return -1;
      if (m_locked && r[m_owner]) return m_owner;
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(m_owner + k) % NREQ]) return (m_owner + k) % NREQ;
      end
      return -1;
   endfunction

   // One clock: drive at posedge+1, check at negedge, commit FIFO and model at posedge.
   task automatic cycle(input logic [NREQ-1:0] r, input bit pop);
      int              w;
      logic [NREQ-1:0] eg;
      logic [DW-1:0]   ed;
      logic            wr;
      logic [DW-1:0]   wd;
      logic [DW-1:0]   got;
      logic [DW-1:0]   want;
      req       = r;
      fifo_full = (fifo_q.size() >= DEPTH);
      @(negedge clk);
      w  = exp_winner(r, fifo_full);
      eg = '0;
      ed = '0;
      if (w >= 0) begin
         eg[w] = 1'b1;
         ed    = data_in[w*DW +: DW];
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("wr_en", 32'(fifo_wr_en), 32'(|eg));
      check("data", 32'(fifo_data), 32'(ed));
      check("owner", 32'(owner), 32'(m_owner));
      last_gnt = gnt;
      wr       = fifo_wr_en;
      wd       = fifo_data;
      @(posedge clk);
      check("no_overflow", 32'(wr && fifo_q.size() >= DEPTH), 32'd0);
      if (pop && fifo_q.size() > 0) begin
         got  = fifo_q.pop_front();
         want = 'x;
         if (exp_q.size() > 0) want = exp_q.pop_front();
         check("rd_data", 32'(got), 32'(want));
      end
      if (wr) fifo_q.push_back(wd);
      if (w >= 0) begin
         exp_q.push_back(ed);
         if (BurstOn) begin
            if (m_locked && w == m_owner) begin
               m_burst_n++;
               if (m_burst_n >= BL) m_locked = 1'b0;
            end else begin
               m_locked  = 1'b1;
               m_burst_n = 1;
            end
         end
         m_owner = w;
      end else if (m_locked && !r[m_owner]) begin
         m_locked = 1'b0;
      end
      #1;
   endtask

   task automatic rst_checks();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_data", 32'(fifo_data), 32'd0);
      check("rst_owner", 32'(owner), NREQ - 1);
   endtask

   task automatic do_reset(input logic [NREQ-1:0] r);
      req       = r;
      fifo_full = 1'b0;
      rst       = 1'b1;
      m_owner   = NREQ - 1;
      m_locked  = 1'b0;
      m_burst_n = 0;
      #1;
      rst_checks();
      repeat (2) @(posedge clk);
      #1;
      rst_checks();
      fifo_q.delete();
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 4 && fifo_q.size() > 0; i++) cycle('0, 1'b1);
      check("drained", fifo_q.size(), 32'd0);
      check("exp_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [NREQ-1:0] seq[5];
      logic [DW-1:0]   rd[4];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rd  = '{5'd3, 5'd9, 5'd3, 5'd9};
      data_in = {5'd13, 5'd12, 5'd11, 5'd10};

      // Reset with everyone requesting; requester 0 wins first.
      do_reset(4'b1111);
      cycle(4'b1111, 1'b0);
      check("first_gnt", 32'(last_gnt), 32'b0001);
      drain();

      // Full-rotation sequence and readback order.
      do_reset(4'b1111);
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 1'b0);
`ifndef FIFO_ARB_BURST_EN
         check("rr_seq", 32'(last_gnt), 32'(seq[i]));
         check("rr_rd", 32'(fifo_q[i]), 32'(10 + (i % 4)));
`endif
      end
      drain();

      // Two sparse requesters alternate; idle ones never granted.
      do_reset(4'b0101);
      data_in = {5'd0, 5'd9, 5'd0, 5'd3};
      for (int i = 0; i < 4; i++) begin
         cycle(4'b0101, 1'b0);
         check("idle_never", 32'(last_gnt & 4'b1010), 32'd0);
`ifndef FIFO_ARB_BURST_EN
         check("alt_rd", 32'(fifo_q[i]), 32'(rd[i]));
`endif
      end
      drain();

      // Fill to capacity, stall, free one slot, exactly one grant.
      data_in = {5'd23, 5'd22, 5'd21, 5'd20};
      for (int i = 0; i < DEPTH + 8 && fifo_q.size() < DEPTH; i++) cycle(4'b1111, 1'b0);
      check("fill_size", fifo_q.size(), DEPTH);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b1111, 1'b0);
         check("full_gnt", 32'(last_gnt), 32'd0);
      end
      cycle(4'b1111, 1'b1);
      check("full_pop_gnt", 32'(last_gnt), 32'd0);
      cycle(4'b1111, 1'b0);
      check("one_gnt", $countones(last_gnt), 32'd1);
      cycle(4'b1111, 1'b0);
      check("refull_gnt", 32'(last_gnt), 32'd0);
      check("refill_size", fifo_q.size(), DEPTH);
      drain();

`ifdef FIFO_ARB_BURST_EN
      // Bursts of BL to each of two requesters.
      do_reset(4'b0011);
      for (int i = 0; i < 2 * BL; i++) begin
         cycle(4'b0011, 1'b0);
         check("burst_seq", 32'(last_gnt), (i < BL) ? 32'b0001 : 32'b0010);
      end
      // Owner drops mid-burst: hand-off on the next edge.
      do_reset(4'b0011);
      cycle(4'b0011, 1'b0);
      cycle(4'b0011, 1'b0);
      cycle(4'b0010, 1'b0);
      check("handoff", 32'(last_gnt), 32'b0010);
      drain();
`endif

      // Reset asserted mid-burst aborts at once; arbitration restarts from requester 0.
      do_reset(4'b0011);
      cycle(4'b0011, 1'b0);
      cycle(4'b0011, 1'b0);
      do_reset(4'b0011);
      for (int i = 0; i < BL + 1; i++) begin
         cycle(4'b0011, 1'b0);
`ifdef FIFO_ARB_BURST_EN
         check("post_rst_burst", 32'(last_gnt), (i < BL) ? 32'b0001 : 32'b0010);
`else
         check("post_rst_rr", 32'(last_gnt), (i % 2 == 0) ? 32'b0001 : 32'b0010);
`endif
      end
      drain();

      // Random traffic with sparse reads so the FIFO fills and stalls.
      for (int i = 0; i < 600; i++) begin
         data_in = (NREQ * DW)'($urandom);
         cycle(NREQ'($urandom), $urandom_range(0, 3) == 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
